// File: rtl/biquad_mac_sched.sv
// Direct-form-I biquad built around one shared CW x DW signed multiplier.
// An accepted sample is evaluated over five MAC states, then scaled and
// emitted. y_valid rises 7 cycles after the edge that accepts sample_tick.
// Optional macro BIQUAD_SAT_EN: saturate the scaled result to DW bits.
// Without the macro the scaled result wraps to its low DW bits.
// The accumulator width AW is expected to satisfy AW >= DW+CW+3.
module biquad_mac_sched #(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int FRAC = 14,
  parameter int AW   = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [CW-1:0] b0,
  input  logic signed [CW-1:0] b1,
  input  logic signed [CW-1:0] b2,
  input  logic signed [CW-1:0] a1,
  input  logic signed [CW-1:0] a2,
  input  logic                 clr_hist,
  output logic signed [DW-1:0] y_out,
  output logic                 y_valid,
  output logic                 busy,
  output logic                 overrun
);

  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, MAC3, MAC4, SCALE, OUT} state_t;

  state_t                state_q, state_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [DW-1:0]  x_q, x_d, x1_q, x1_d, x2_q, x2_d;
  logic signed [DW-1:0]  y1_q, y1_d, y2_q, y2_d;
  logic signed [DW-1:0]  y_res_q, y_res_d;
  logic signed [DW-1:0]  y_out_q, y_out_d;
  logic                  y_valid_q, y_valid_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

  logic signed [CW-1:0]    mul_coef;
  logic signed [DW-1:0]    mul_data;
  logic                    mul_sub;
  logic signed [CW+DW-1:0] prod;
  logic signed [AW-1:0]    prod_ext;
  logic signed [DW-1:0]    reduced;

  // Select the coefficient/operand pair for the shared multiplier by MAC state.
  always_comb begin
    mul_coef = b0;
    mul_data = x_q;
    mul_sub  = 1'b0;
    case (state_q)
      MAC1: begin mul_coef = b1; mul_data = x1_q; end
      MAC2: begin mul_coef = b2; mul_data = x2_q; end
      MAC3: begin mul_coef = a1; mul_data = y1_q; mul_sub = 1'b1; end
      MAC4: begin mul_coef = a2; mul_data = y2_q; mul_sub = 1'b1; end
      default: ;
    endcase
  end

  assign prod     = mul_coef * mul_data;
  assign prod_ext = {{(AW-CW-DW){prod[CW+DW-1]}}, prod};

`ifdef BIQUAD_SAT_EN
  localparam logic signed [AW-1:0] Y_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] Y_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  logic signed [AW-1:0] shifted;
  assign shifted = acc_q >>> FRAC;
  // Clamp the floor-scaled accumulator into the DW-bit signed range.
  always_comb begin
    reduced = shifted[DW-1:0];
    if (shifted > Y_MAX)      reduced = Y_MAX[DW-1:0];
    else if (shifted < Y_MIN) reduced = Y_MIN[DW-1:0];
  end
`else
  // Arithmetic shift then wrap equals taking DW bits starting at FRAC.
  assign reduced = acc_q[FRAC +: DW];
`endif

  // Next-state, datapath and output computation for the whole schedule.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    x_d       = x_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    y1_d      = y1_q;
    y2_d      = y2_q;
    y_res_d   = y_res_q;
    y_out_d   = y_out_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        // History clear lands on the same edge as a capture, so the
        // evaluation that starts here already sees zero history.
        if (clr_hist) begin
          x1_d = '0;
          x2_d = '0;
          y1_d = '0;
          y2_d = '0;
        end
        if (sample_tick) begin
          x_d     = x_in;
          acc_d   = '0;
          state_d = MAC0;
        end
      end
      MAC0, MAC1, MAC2, MAC3, MAC4: begin
        acc_d   = mul_sub ? (acc_q - prod_ext) : (acc_q + prod_ext);
        state_d = (state_q == MAC4) ? SCALE : state_t'(state_q + 3'd1);
      end
      SCALE: begin
        y_res_d = reduced;
        state_d = OUT;
      end
      OUT: begin
        y_out_d = y_res_q;
        x2_d    = x1_q;
        x1_d    = x_q;
        y2_d    = y1_q;
        y1_d    = y_res_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Any tick outside IDLE (including OUT) is dropped and flagged.
    if (sample_tick && (state_q != IDLE)) overrun_d = 1'b1;
    y_valid_d = (state_q == OUT);
    busy_d    = (state_d != IDLE);
  end

  // State and datapath registers; reset aborts any evaluation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      x_q       <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      y_res_q   <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      x_q       <= x_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      y1_q      <= y1_d;
      y2_q      <= y2_d;
      y_res_q   <= y_res_d;
      y_out_q   <= y_out_d;
      y_valid_q <= y_valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_biquad_mac_sched.sv
// Bench for biquad_mac_sched: directed scenarios plus randomized samples
// checked against an arithmetic direct-form-I reference model.
module tb_biquad_mac_sched;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               sample_tick = 1'b0;
  logic signed [15:0] x_in = '0;
  logic signed [15:0] b0 = '0, b1 = '0, b2 = '0, a1 = '0, a2 = '0;
  logic               clr_hist = 1'b0;
  logic signed [15:0] y_out;
  logic               y_valid, busy, overrun;

  int compared = 0;
  int mismatched = 0;

  // Reference model history (holds reduced y values).
  longint m_x1 = 0, m_x2 = 0, m_y1 = 0, m_y2 = 0, m_yout = 0;

  biquad_mac_sched dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .x_in(x_in),
    .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2), .clr_hist(clr_hist),
    .y_out(y_out), .y_valid(y_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // y = (b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2) / 2^14 floored, then reduced to 16 bits.
  task automatic model_eval(input longint x, output longint y);
    longint acc, s;
    logic signed [63:0] sv;
    logic signed [15:0] t;
    acc = longint'(b0) * x + longint'(b1) * m_x1 + longint'(b2) * m_x2
        - longint'(a1) * m_y1 - longint'(a2) * m_y2;
    s = acc >>> 14;
`ifdef BIQUAD_SAT_EN
    if (s > 32767) y = 32767;
    else if (s < -32768) y = -32768;
    else y = s;
`else
    sv = s;
    t = sv[15:0];
    y = t;
`endif
    m_x2 = m_x1; m_x1 = x; m_y2 = m_y1; m_y1 = y; m_yout = y;
  endtask

  task automatic model_clear();
    m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
  endtask

  // One sample: tick, watch latency/busy/hold, compare against the model.
  task automatic run_sample(input string tag, input logic signed [15:0] x,
                            input logic clr, input logic clr_busy,
                            output longint y_exp);
    int lat;
    longint prev;
    prev = m_yout;
    @(negedge clk);
    sample_tick = 1'b1; x_in = x; clr_hist = clr;
    if (clr) model_clear();
    model_eval(longint'(x), y_exp);
    @(posedge clk); #1;
    sample_tick = 1'b0; clr_hist = clr_busy;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (y_valid) begin lat = k; break; end
      check({tag, ".hold"}, y_out, prev);
      check({tag, ".busy"}, busy, 1);
    end
    clr_hist = 1'b0;
    check({tag, ".latency"}, lat, 7);
    check({tag, ".y"}, y_out, y_exp);
    check({tag, ".idle"}, busy, 0);
    $display("sample %s x=%0d y_out=%0d expected=%0d latency=%0d", tag, x, y_out, y_exp, lat);
  endtask

  // Accept a tick, then drive another one sampled at edge second_k.
  task automatic dual_tick(input string tag, input logic signed [15:0] x, input int second_k);
    int cnt;
    longint y_exp;
    @(negedge clk);
    sample_tick = 1'b1; x_in = x;
    model_eval(longint'(x), y_exp);
    @(posedge clk); #1;
    cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      sample_tick = (k == second_k);
      @(posedge clk); #1;
      if (y_valid) cnt++;
    end
    sample_tick = 1'b0;
    check({tag, ".valids"}, cnt, 1);
    check({tag, ".overrun"}, overrun, 1);
    check({tag, ".y"}, y_out, y_exp);
    $display("dual_tick %s second_at=%0d valids=%0d overrun=%0b y_out=%0d", tag, second_k, cnt, overrun, y_out);
  endtask

  initial begin
    longint y;
    int cnt;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.y_out", y_out, 0);
    check("rst.y_valid", y_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.overrun", overrun, 0);
    @(negedge clk); reset = 1'b1;

    // Pass-through gain 1.0
    b0 = 16384;
    run_sample("pass", 16'sd1000, 1'b0, 1'b0, y);
    check("pass.const", y_out, 1000);

    // Pure one-sample delay, clear coinciding with the first tick
    b0 = 0; b1 = 16384;
    run_sample("delay0", 16'sd500, 1'b1, 1'b0, y);
    check("delay0.const", y_out, 0);
    run_sample("delay1", -16'sd300, 1'b0, 1'b0, y);
    check("delay1.const", y_out, 500);

    // First-order recursion y = x + 0.5*y1
    b1 = 0; b0 = 16384; a1 = -8192;
    run_sample("iir0", 16'sd1000, 1'b1, 1'b0, y);
    check("iir0.const", y_out, 1000);
    run_sample("iir1", 16'sd0, 1'b0, 1'b0, y);
    check("iir1.const", y_out, 500);
    run_sample("iir2", 16'sd0, 1'b0, 1'b0, y);
    check("iir2.const", y_out, 250);

    // Overflow of the reduced result
    a1 = 0; b0 = 16384; b1 = 16384;
    run_sample("ovf0", 16'sd32767, 1'b1, 1'b0, y);
    check("ovf0.const", y_out, 32767);
    run_sample("ovf1", 16'sd32767, 1'b0, 1'b0, y);
`ifdef BIQUAD_SAT_EN
    check("ovf1.const", y_out, 32767);
`else
    check("ovf1.const", y_out, -2);
`endif

    // Tick while busy (cycle 3) is dropped and flagged
    b1 = 0;
    dual_tick("ovr3", 16'sd1234, 3);

    // Reset at cycle 4 of an evaluation aborts it
    @(negedge clk);
    sample_tick = 1'b1; x_in = 16'sd777;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    model_clear(); m_yout = 0;
    @(negedge clk); reset = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (y_valid) cnt++;
    end
    check("abort.valids", cnt, 0);
    check("abort.y_out", y_out, 0);
    check("abort.busy", busy, 0);
    check("abort.overrun", overrun, 0);
    $display("abort valids=%0d y_out=%0d overrun=%0b", cnt, y_out, overrun);
    b1 = 16384; a1 = 16'sh1000;
    run_sample("post_rst", 16'sd2000, 1'b0, 1'b0, y);
    check("post_rst.const", y_out, 2000);

    // Tick coinciding with OUT is also an overrun
    dual_tick("ovr_out", -16'sd4321, 7);

    // Randomized coefficients, samples and history clears
    for (int i = 0; i < 40; i++) begin
      b0 = 16'($urandom); b1 = 16'($urandom); b2 = 16'($urandom);
      a1 = 16'($urandom); a2 = 16'($urandom);
      if (i % 2 == 0) begin
        b0 = b0 >>> 2; b1 = b1 >>> 2; b2 = b2 >>> 2; a1 = a1 >>> 3; a2 = a2 >>> 3;
      end
      run_sample($sformatf("rnd%0d", i), 16'($urandom),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), y);
    end
    check("sticky.overrun", overrun, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
